// File: rtl/gpio_bank_ctrl_if.sv
// Serial control bus with registered readback port, shared by the FR_* register decoders.
interface gpio_bank_ctrl_if;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic [6:0]  rb_addr;
  logic [31:0] rb_data;

  modport master (
    output serial_addr, serial_data, serial_strobe, rb_addr,
    input  rb_data
  );

  modport slave (
    input  serial_addr, serial_data, serial_strobe, rb_addr,
    output rb_data
  );
endinterface

// File: rtl/gpio_bank_ctrl.sv
// GPIO bank controller: masked-write direction/value/source registers, synchronised
// inputs with sticky edge status, level interrupt and registered readback.
module gpio_bank_ctrl #(
  parameter int         NBANKS      = 2,
  parameter int         WIDTH       = 16,
  parameter logic [6:0] BASE_ADDR   = 7'd64,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  gpio_bank_ctrl_if.slave         bus,
  input  logic [NBANKS*WIDTH-1:0] io_in,
  input  logic [NBANKS*WIDTH-1:0] ext_val,
  output logic [NBANKS*WIDTH-1:0] io_out,
  output logic [NBANKS*WIDTH-1:0] io_oe,
  output logic                    irq
);
  localparam int         N     = NBANKS * WIDTH;
  localparam logic [7:0] BASE8 = {1'b0, BASE_ADDR};
  localparam logic [7:0] SPAN  = 8'(8 * NBANKS);

  typedef enum logic [2:0] {
    REG_OE     = 3'd0,
    REG_OUT    = 3'd1,
    REG_SRC    = 3'd2,
    REG_EDGE   = 3'd3,
    REG_STATUS = 3'd4,
    REG_PIN    = 3'd5
  } reg_e;

  logic [NBANKS-1:0][WIDTH-1:0] oe_q, out_q, src_q, rise_q, fall_q, status_q;
  logic [NBANKS-1:0][WIDTH-1:0] status_d, evt, sync_b, prev_b;
  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]                  prev_q;
  logic [31:0]                   rb_next;

  logic [7:0] wr_rel, rb_rel;
  logic       wr_hit, rb_hit;
  logic [2:0] wr_bank, rb_bank;
  reg_e       wr_reg, rb_reg;

  assign wr_rel  = {1'b0, bus.serial_addr} - BASE8;
  assign wr_hit  = bus.serial_strobe && ({1'b0, bus.serial_addr} >= BASE8) && (wr_rel < SPAN);
  assign wr_bank = wr_rel[5:3];
  assign wr_reg  = reg_e'(wr_rel[2:0]);

  assign rb_rel  = {1'b0, bus.rb_addr} - BASE8;
  assign rb_hit  = ({1'b0, bus.rb_addr} >= BASE8) && (rb_rel < SPAN);
  assign rb_bank = rb_rel[5:3];
  assign rb_reg  = reg_e'(rb_rel[2:0]);

  // Only pins whose mask bit (upper half of the data word) is set take the new value.
  function automatic logic [WIDTH-1:0] masked(input logic [WIDTH-1:0] old, input logic [31:0] d);
    logic [WIDTH-1:0] m, v;
    m = d[16 +: WIDTH];
    v = d[WIDTH-1:0];
    return (old & ~m) | (v & m);
  endfunction

  assign sync_b = sync_q[SYNC_STAGES-1];
  assign prev_b = prev_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    status_d = status_q;
    rb_next  = '0;
    for (int b = 0; b < NBANKS; b++) begin
      evt[b] = (sync_b[b] & ~prev_b[b] & rise_q[b]) | (~sync_b[b] & prev_b[b] & fall_q[b]);
      // Clear first, then OR in events, so a coincident set wins.
      if (wr_hit && wr_bank == 3'(b) && wr_reg == REG_STATUS)
        status_d[b] = status_q[b] & ~bus.serial_data[WIDTH-1:0];
      status_d[b] = status_d[b] | evt[b];
      if (rb_hit && rb_bank == 3'(b)) begin
        case (rb_reg)
          REG_OE:     rb_next = 32'(oe_q[b]);
          REG_OUT:    rb_next = 32'(out_q[b]);
          REG_SRC:    rb_next = 32'(src_q[b]);
          REG_EDGE:   rb_next = {16'(fall_q[b]), 16'(rise_q[b])};
          REG_STATUS: rb_next = 32'(status_q[b]);
          REG_PIN:    rb_next = 32'(sync_b[b]);
          default:    rb_next = '0;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      oe_q        <= '0;
      out_q       <= '0;
      src_q       <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      status_q    <= '0;
      sync_q      <= '0;
      prev_q      <= '0;
      bus.rb_data <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], io_in};
      prev_q      <= sync_q[SYNC_STAGES-1];
      status_q    <= status_d;
      bus.rb_data <= rb_next;
      for (int b = 0; b < NBANKS; b++) begin
        if (wr_hit && wr_bank == 3'(b)) begin
          case (wr_reg)
            REG_OE:   oe_q[b]  <= masked(oe_q[b], bus.serial_data);
            REG_OUT:  out_q[b] <= masked(out_q[b], bus.serial_data);
            REG_SRC:  src_q[b] <= masked(src_q[b], bus.serial_data);
            REG_EDGE: begin
              rise_q[b] <= bus.serial_data[WIDTH-1:0];
              fall_q[b] <= bus.serial_data[16 +: WIDTH];
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign io_oe  = oe_q;
  assign io_out = (src_q & ext_val) | (~src_q & out_q);
  assign irq    = |status_q;
endmodule
